// File: rtl/ps2_host_tx_if.sv
// Handshake and open-drain line bundle between a PS/2 host transmitter and its user.
// The slave modport is the transmitter side; master is the user/device-model side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;
  logic       scl;
  logic       sda;
  logic       scl_oe;
  logic       sda_oe;

  modport slave (
    input  tx_data, tx_valid, scl, sda,
    output tx_ready, tx_done, tx_err, busy, scl_oe, sda_oe
  );

  modport master (
    output tx_data, tx_valid, scl, sda,
    input  tx_ready, tx_done, tx_err, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame clocked by the device, ACK check.
// Define PS2_TX_TIMEOUT_EN to add a per-frame watchdog of TIMEOUT_CYCLES clocks.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;

  logic scl_m_q, scl_s_q, scl_prev_q;
  logic sda_m_q, sda_s_q;
  logic scl_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Idle PS/2 lines are pulled high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m_q    <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_m_q    <= 1'b1;
      sda_s_q    <= 1'b1;
    end else begin
      scl_m_q    <= bus.scl;
      scl_s_q    <= scl_m_q;
      scl_prev_q <= scl_s_q;
      sda_m_q    <= bus.sda;
      sda_s_q    <= sda_m_q;
    end
  end

  assign scl_fall = scl_prev_q & ~scl_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    tx_ready_d = tx_ready_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (bus.tx_valid && tx_ready_q) begin
          frame_d    = {1'b1, ~^bus.tx_data, bus.tx_data};
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          scl_oe_d   = 1'b1;
          sda_oe_d   = 1'b0;
          inh_cnt_d  = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          sda_oe_d = 1'b1;
          state_d  = RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      RTS: begin
        scl_oe_d  = 1'b0;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      // Frame index 0..7 data, 8 parity, 9 stop; the start bit is already on the line from RTS.
      SHIFT: begin
        if (scl_fall) begin
          sda_oe_d  = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (scl_fall) begin
          bit_cnt_d = 4'd10;
          if (!sda_s_q) tx_done_d = 1'b1;
          else          tx_err_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (scl_s_q && sda_s_q) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // The watchdog overrides any same-cycle ACK result so done and err never coincide.
    if (state_q == RTS || state_q == SHIFT || state_q == ACK) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TO_LAST) begin
        scl_oe_d  = 1'b0;
        sda_oe_d  = 1'b0;
        tx_done_d = 1'b0;
        tx_err_d  = 1'b1;
        state_d   = WAIT_IDLE;
      end
    end
`endif
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_err   = tx_err_q;
  assign bus.busy     = busy_q;
  assign bus.scl_oe   = scl_oe_q;
  assign bus.sda_oe   = sda_oe_q;

endmodule
